// File: rtl/eth_hdmi_pkg.sv
// Shared definitions for the Ethernet-to-HDMI line RAM path: RAM geometry,
// packet header field positions and the receive-packer state encoding.
package eth_hdmi_pkg;

  localparam int ETH_RAM_AW    = 13;
  localparam int ETH_RAM_DEPTH = 8192;

  localparam int HDR_FS_BIT   = 15;
  localparam int HDR_ADDR_MSB = 12;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    DROP
  } rx_state_e;

  // Start address carried in the header: high-byte address bits above the low header byte.
  function automatic logic [HDR_ADDR_MSB:0] hdr_addr(input logic [HDR_ADDR_MSB-8:0] ahi,
                                                     input logic [7:0]              lo);
    return {ahi, lo};
  endfunction

endpackage

// File: rtl/eth_rx_pix_packer_if.sv
// Byte-stream input and RAM write-port output of the receive pixel packer.
// master = stream source / RAM side, slave = the packer itself.
interface eth_rx_pix_packer_if #(
  parameter int ADDR_W = eth_hdmi_pkg::ETH_RAM_AW
);
  logic              rec_en;
  logic [7:0]        rec_data;
  logic              rec_pkt_start;
  logic              rec_pkt_done;
  logic [ADDR_W-1:0] des_addr;
  logic [15:0]       des_data;
  logic              eth_wr_ram_en;
  logic              frame_start;
  logic              pkt_err;
  logic [15:0]       pkt_cnt;

  modport master (
    output rec_en, rec_data, rec_pkt_start, rec_pkt_done,
    input  des_addr, des_data, eth_wr_ram_en, frame_start, pkt_err, pkt_cnt
  );

  modport slave (
    input  rec_en, rec_data, rec_pkt_start, rec_pkt_done,
    output des_addr, des_data, eth_wr_ram_en, frame_start, pkt_err, pkt_cnt
  );
endinterface

// File: rtl/eth_rx_pix_packer.sv
// Packs UDP payload bytes (2-byte header, then hi/lo pixel bytes) into RGB565
// words and drives the line RAM write port one cycle after each low byte.
module eth_rx_pix_packer
  import eth_hdmi_pkg::*;
#(
  parameter int ADDR_W    = ETH_RAM_AW,
  parameter int DEPTH     = ETH_RAM_DEPTH,
  parameter int MAX_WORDS = 4096
) (
  input logic              clk_ref,
  input logic              sys_rst,
  eth_rx_pix_packer_if.slave bus
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  rx_state_e                 state_q, state_d, state_b;
  logic                      hdr_fs_q, hdr_fs_d;
  logic [HDR_ADDR_MSB-8:0]   hdr_ahi_q, hdr_ahi_d;
  logic [7:0]                hi_q, hi_d, hi_b;
  logic [ADDR_W-1:0]         addr_q, addr_d, addr_b;
  logic [WC_W-1:0]           wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]         des_addr_q, des_addr_d;
  logic [15:0]               des_data_q, des_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      frame_start_q, frame_start_d;
  logic                      pkt_err_q, pkt_err_d;
  logic [15:0]               pkt_cnt_q, pkt_cnt_d;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  always_comb begin
    state_b       = state_q;
    hdr_fs_d      = hdr_fs_q;
    hdr_ahi_d     = hdr_ahi_q;
    hi_b          = hi_q;
    addr_b        = addr_q;
    wcnt_d        = wcnt_q;
    des_addr_d    = des_addr_q;
    des_data_d    = des_data_q;
    wr_en_d       = 1'b0;
    frame_start_d = 1'b0;
    pkt_err_d     = 1'b0;
    pkt_cnt_d     = pkt_cnt_q;

    // The incoming byte is consumed first; the done rule then sees the resulting state.
    if (bus.rec_en) begin
      if (bus.rec_pkt_start) begin
        state_b   = HDR_LO;
        hdr_fs_d  = bus.rec_data[HDR_FS_BIT-8];
        hdr_ahi_d = bus.rec_data[HDR_ADDR_MSB-8:0];
      end else begin
        case (state_q)
          HDR_LO: begin
            addr_b        = ADDR_W'(hdr_addr(hdr_ahi_q, bus.rec_data));
            frame_start_d = hdr_fs_q;
            wcnt_d        = '0;
            state_b       = DATA_HI;
          end
          DATA_HI: begin
            if (wcnt_q == WC_W'(MAX_WORDS)) begin
              pkt_err_d = 1'b1;
              state_b   = DROP;
            end else begin
              hi_b    = bus.rec_data;
              state_b = DATA_LO;
            end
          end
          DATA_LO: begin
            des_addr_d = addr_q;
            des_data_d = {hi_q, bus.rec_data};
            wr_en_d    = 1'b1;
            addr_b     = addr_next(addr_q);
            wcnt_d     = wcnt_q + WC_W'(1);
            state_b    = DATA_HI;
          end
          default: ;
        endcase
      end
    end

    if (bus.rec_pkt_done) begin
      case (state_b)
        DATA_HI: pkt_cnt_d = pkt_cnt_q + 16'd1;
        DATA_LO: begin
          // Odd byte count: flush the dangling high byte padded with zero.
          des_addr_d = addr_b;
          des_data_d = {hi_b, 8'h00};
          wr_en_d    = 1'b1;
          pkt_err_d  = 1'b1;
        end
        IDLE, HDR_LO: pkt_err_d = 1'b1;
        default: ;
      endcase
      state_b = IDLE;
    end

    state_d = state_b;
    hi_d    = hi_b;
    addr_d  = addr_b;
  end

  always_ff @(posedge clk_ref or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      hdr_fs_q      <= 1'b0;
      hdr_ahi_q     <= '0;
      hi_q          <= '0;
      addr_q        <= '0;
      wcnt_q        <= '0;
      des_addr_q    <= '0;
      des_data_q    <= '0;
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pkt_err_q     <= 1'b0;
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hdr_fs_q      <= hdr_fs_d;
      hdr_ahi_q     <= hdr_ahi_d;
      hi_q          <= hi_d;
      addr_q        <= addr_d;
      wcnt_q        <= wcnt_d;
      des_addr_q    <= des_addr_d;
      des_data_q    <= des_data_d;
      wr_en_q       <= wr_en_d;
      frame_start_q <= frame_start_d;
      pkt_err_q     <= pkt_err_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  assign bus.des_addr      = des_addr_q;
  assign bus.des_data      = des_data_q;
  assign bus.eth_wr_ram_en = wr_en_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.pkt_err       = pkt_err_q;
  assign bus.pkt_cnt       = pkt_cnt_q;

endmodule
